// File: rtl/led_scan_sequencer_pkg.sv
// Shared types for the LED scan sequencer: command opcodes and FSM states.
package led_seq_pkg;

    typedef enum logic [1:0] {
        CMD_STOP    = 2'd0,
        CMD_RUN     = 2'd1,
        CMD_STEP    = 2'd2,
        CMD_SET_DIV = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/led_scan_sequencer_if.sv
// Valid/ready command port of the LED scan sequencer.
// The host drives the master side; the sequencer is the slave.
interface led_scan_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    cmd_op_t              cmd_op;
    logic [DIV_WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );

endinterface

// File: rtl/led_scan_sequencer_prescaler.sv
// Programmable prescaler: holds the divider and a free-running count that
// wraps at the divider value. tick_o is combinational on the current count so
// the caller can register it into a strobe one cycle later.
module led_seq_prescaler #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 999
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] load_val_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == div_q);

    // Next divider and count: a load or clear restarts the count from zero.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_i) begin
            div_d = load_val_i;
        end
        if (clear_i || load_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Divider and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= DIV_WIDTH'(DEFAULT_DIV);
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_sequencer.sv
// LED scan sequencer: paces the scanner's one-cycle advance strobe from a
// programmable prescaler, accepts STOP/RUN/STEP/SET_DIV commands and tracks the
// position inside the bounce period.
// Optional feature macro: LED_SEQ_CYCLE_LIMIT_EN (RUN's cmd_arg limits the
// number of full bounce cycles; 0 runs forever).
module led_scan_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV     = 999,
    parameter int unsigned STEPS_PER_CYCLE = 10,
    localparam int unsigned IDX_W          = $clog2(STEPS_PER_CYCLE)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    led_scan_sequencer_if.slave  cmd,
    output logic                 advance_o,
    output logic                 running_o,
    output logic [IDX_W-1:0]     step_idx_o,
    output logic                 cycle_done_o
);

    seq_state_t       state_q, state_d;
    logic             adv_q, adv_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic accept;
    logic acc_run, acc_stop, acc_step, acc_set_div;
    logic tick_raw, tick;
    logic limit_hit;

    assign cmd.cmd_ready = (state_q != S_STEP);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign acc_run       = accept && (cmd.cmd_op == CMD_RUN);
    assign acc_stop      = accept && (cmd.cmd_op == CMD_STOP);
    assign acc_step      = accept && (cmd.cmd_op == CMD_STEP);
    assign acc_set_div   = accept && (cmd.cmd_op == CMD_SET_DIV);

`ifdef LED_SEQ_CYCLE_LIMIT_EN
    logic [DIV_WIDTH-1:0] rem_q, rem_d;

    // The cycle_done that consumes the last remaining cycle ends the run; the
    // tick coinciding with it is suppressed so no extra advance leaks out.
    assign limit_hit = (state_q == S_RUN) && done_q && (rem_q == DIV_WIDTH'(1));

    // Remaining-cycles counter: reload on RUN, clear on STOP, count cycle_done.
    always_comb begin
        rem_d = rem_q;
        if ((state_q == S_RUN) && done_q && (rem_q != '0)) begin
            rem_d = rem_q - 1'b1;
        end
        if (acc_stop) begin
            rem_d = '0;
        end else if (acc_run) begin
            rem_d = cmd.cmd_arg;
        end
    end

    // Remaining-cycles register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    assign tick = tick_raw && !limit_hit;

    led_seq_prescaler #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (acc_set_div),
        .load_val_i (cmd.cmd_arg),
        .clear_i    ((state_q != S_RUN) || acc_run || acc_stop),
        .enable_i   (state_q == S_RUN),
        .tick_o     (tick_raw)
    );

    // FSM next state and advance strobe; a tick due this cycle is honoured
    // even when a command changes the mode at the same edge.
    always_comb begin
        state_d = state_q;
        adv_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_run) begin
                    state_d = S_RUN;
                end else if (acc_step) begin
                    state_d = S_STEP;
                    adv_d   = 1'b1;
                end
            end
            S_RUN: begin
                adv_d = tick;
                if (acc_stop) begin
                    state_d = S_IDLE;
                end else if (acc_run) begin
                    state_d = S_RUN;
                end else if (limit_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Position within the bounce period, updated together with the strobe.
    always_comb begin
        idx_d  = idx_q;
        done_d = 1'b0;
        if (adv_d) begin
            if (idx_q == IDX_W'(STEPS_PER_CYCLE - 1)) begin
                idx_d  = '0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            adv_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            adv_q   <= adv_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign advance_o    = adv_q;
    assign cycle_done_o = done_q;
    assign step_idx_o   = idx_q;
    assign running_o    = (state_q == S_RUN);

endmodule
